nlu_anf_driver: RTL and testbench

NLU_ANF_DRIVER -- requirements
Module: nlu_anf_driver

---
 rtl/nlu_anf_driver.sv | 187 ++++++++++++++++++
 tb/tb_nlu_anf_driver.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nlu_anf_driver.sv
// nlu_anf_driver: loads a 64-bit nonlinear ANF mask into the NLU, then streams
// 32-bit data words through it. Each result is captured LAT cycles after its
// word is presented and queued in a result FIFO. Credits (in-flight words plus
// queued results) stop the FIFO from overflowing.
module nlu_anf_driver #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        mask_valid,
    input  logic [63:0] mask_data,
    output logic        mask_ready,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic [31:0] nlu_dinp,
    output logic        nlu_pushnl,
    output logic        nlu_mode,
    output logic        nlu_modenl,
    output logic        nlu_pushl,
    output logic        nlu_acc,
    output logic        nlu_mac,
    output logic [3:0]  nlu_sel,
    output logic [1:0]  nlu_sro,
    input  logic [31:0] nlu_dout
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {NOMASK, LOAD, RUN, DRAIN} state_t;

    state_t         state_q;
    logic [63:0]    mask_q;
    logic [1:0]     word_q;
    logic [31:0]    dinp_q;
    logic           pushnl_q;
    logic           issue_q;
    logic [LAT-1:0] vsr_q, vsr_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  fcnt_q, fcnt_d;
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [31:0]    fifo_q [DEPTH];

    logic [CW:0] credit_used;
    logic        mask_fire, in_fire, fifo_wr, fifo_rd;

    // 16-bit mask word idx, most significant word first
    function automatic logic [15:0] mask_word(input logic [63:0] m, input logic [1:0] idx);
        case (idx)
            2'd0:    return m[63:48];
            2'd1:    return m[47:32];
            2'd2:    return m[31:16];
            default: return m[15:0];
        endcase
    endfunction

    // FIFO pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign credit_used = {1'b0, outst_q} + {1'b0, fcnt_q};
    assign mask_fire   = mask_valid & mask_ready;
    assign in_fire     = in_valid & in_ready;
    assign fifo_wr     = vsr_q[LAT-1];
    assign fifo_rd     = out_valid & out_ready;

    assign out_valid  = (fcnt_q != '0);
    assign out_data   = fifo_q[rptr_q];
    assign busy       = rst | (state_q != RUN) | (outst_q != '0);
    assign nlu_dinp   = dinp_q;
    assign nlu_pushnl = pushnl_q;
    assign nlu_mode   = 1'b0;
    assign nlu_modenl = 1'b0;
    assign nlu_pushl  = 1'b0;
    assign nlu_acc    = 1'b0;
    assign nlu_mac    = 1'b1;
    assign nlu_sel    = '0;
    assign nlu_sro    = '0;

    // Handshake readiness: a pending mask always blocks data, and is taken only once nothing is in flight
    always_comb begin
        mask_ready = 1'b0;
        in_ready   = 1'b0;
        if (!rst) begin
            case (state_q)
                NOMASK: mask_ready = 1'b1;
                RUN: begin
                    if (mask_valid) mask_ready = (outst_q == '0);
                    else            in_ready   = (credit_used < DEPTH_C);
                end
                default: ;
            endcase
        end
    end

    // Next values for the capture shift register and the two occupancy counters
    always_comb begin
        vsr_d    = '0;
        vsr_d[0] = issue_q;
        for (int unsigned i = 1; i < LAT; i++) vsr_d[i] = vsr_q[i-1];
        outst_d = outst_q;
        if (in_fire && !fifo_wr)      outst_d = outst_q + 1'b1;
        else if (!in_fire && fifo_wr) outst_d = outst_q - 1'b1;
        fcnt_d = fcnt_q;
        if (fifo_wr && !fifo_rd)      fcnt_d = fcnt_q + 1'b1;
        else if (!fifo_wr && fifo_rd) fcnt_d = fcnt_q - 1'b1;
    end

    // Control FSM with registered NLU drive, credit counters and FIFO pointers
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= NOMASK;
            mask_q   <= '0;
            word_q   <= '0;
            dinp_q   <= '0;
            pushnl_q <= 1'b0;
            issue_q  <= 1'b0;
            vsr_q    <= '0;
            outst_q  <= '0;
            fcnt_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            vsr_q    <= vsr_d;
            outst_q  <= outst_d;
            fcnt_q   <= fcnt_d;
            dinp_q   <= '0;
            pushnl_q <= 1'b0;
            issue_q  <= 1'b0;
            if (fifo_wr) wptr_q <= ptr_inc(wptr_q);
            if (fifo_rd) rptr_q <= ptr_inc(rptr_q);
            case (state_q)
                NOMASK: begin
                    if (mask_fire) begin
                        mask_q   <= mask_data;
                        word_q   <= '0;
                        dinp_q   <= {16'h0, mask_data[63:48]};
                        pushnl_q <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    // word_q names the word on nlu_dinp this cycle; the next one is staged here
                    if (word_q == 2'd3) begin
                        state_q <= RUN;
                    end else begin
                        word_q   <= word_q + 1'b1;
                        dinp_q   <= {16'h0, mask_word(mask_q, word_q + 1'b1)};
                        pushnl_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (mask_fire) begin
                        mask_q   <= mask_data;
                        word_q   <= '0;
                        dinp_q   <= {16'h0, mask_data[63:48]};
                        pushnl_q <= 1'b1;
                        state_q  <= LOAD;
                    end else if (mask_valid) begin
                        state_q <= DRAIN;
                    end else if (in_fire) begin
                        dinp_q  <= in_data;
                        issue_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (outst_q == '0) state_q <= RUN;
                end
                default: state_q <= NOMASK;
            endcase
        end
    end

    // Result storage; reset clears occupancy, not the data words
    always_ff @(posedge ck) begin
        if (!rst && fifo_wr) fifo_q[wptr_q] <= nlu_dout;
    end

endmodule

// File: tb/tb_nlu_anf_driver.sv
// Bench for nlu_anf_driver. It models the NLU as a PRESENT S-box applied
// nibble-wise with LAT cycles of delay. A queue of expected results holds
// words accepted but not yet consumed. The same queue gives the expected
// in_ready credit in RUN.
module tb_nlu_anf_driver;
    localparam int unsigned TLAT   = 2;
    localparam int unsigned TDEPTH = 4;
    localparam logic [63:0] PRESENT_ANF = 64'hE39498F421BC4A80;

    logic        ck = 1'b0;
    logic        rst, mask_valid, in_valid, out_ready;
    logic [63:0] mask_data;
    logic [31:0] in_data;
    logic        mask_ready, in_ready, out_valid, busy, nlu_pushnl;
    logic [31:0] out_data, nlu_dinp, nlu_dout;
    logic        nlu_mode, nlu_modenl, nlu_pushl, nlu_acc, nlu_mac;
    logic [3:0]  nlu_sel;
    logic [1:0]  nlu_sro;

    always #5 ck = ~ck;

    nlu_anf_driver #(.LAT(TLAT), .DEPTH(TDEPTH)) dut (
        .ck(ck), .rst(rst),
        .mask_valid(mask_valid), .mask_data(mask_data), .mask_ready(mask_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .nlu_dinp(nlu_dinp), .nlu_pushnl(nlu_pushnl),
        .nlu_mode(nlu_mode), .nlu_modenl(nlu_modenl), .nlu_pushl(nlu_pushl),
        .nlu_acc(nlu_acc), .nlu_mac(nlu_mac), .nlu_sel(nlu_sel), .nlu_sro(nlu_sro),
        .nlu_dout(nlu_dout)
    );

    function automatic logic [31:0] sbox32(input logic [31:0] x);
        logic [63:0] tbl;
        logic [31:0] r;
        tbl = 64'hC56B90AD3EF84712;
        r = '0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = tbl[60 - 4*int'(x[4*i +: 4]) +: 4];
        return r;
    endfunction

    // NLU model: result of the word on nlu_dinp in cycle c appears on nlu_dout in cycle c+TLAT
    logic [31:0] pipe [TLAT];
    always @(posedge ck) begin
        pipe[0] <= nlu_dinp;
        for (int k = 1; k < TLAT; k++) pipe[k] <= pipe[k-1];
    end
    assign nlu_dout = sbox32(pipe[TLAT-1]);

    int          errors = 0, checks = 0;
    int          accepted = 0, delivered = 0;
    logic [31:0] exp_q [$];
    bit          stalled_prev = 0, prev_issue = 0, run_mode = 0, loading = 0, last_mask_fire = 0;
    logic [31:0] held, prev_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: settle, check the cycle, book handshakes, advance to posedge+1
    task automatic cycle();
        #1;
        if (!rst) begin
            if (stalled_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held);
            end
            if (prev_issue) begin
                chk("issue_dinp", nlu_dinp, prev_data);
                chk("issue_pushnl", nlu_pushnl, 0);
            end else if (!loading) begin
                chk("idle_dinp", nlu_dinp, 0);
                chk("idle_pushnl", nlu_pushnl, 0);
            end
            if (mask_valid)    chk("mask_priority", in_ready, 0);
            else if (run_mode) chk("credit_in_ready", in_ready, exp_q.size() < TDEPTH);
            last_mask_fire = mask_valid && mask_ready;
            if (out_valid && out_ready) begin
                delivered++;
                if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
                else                   chk("out_data", out_data, exp_q.pop_front());
            end
            prev_issue = in_valid && in_ready;
            prev_data  = in_data;
            if (prev_issue) begin
                exp_q.push_back(sbox32(in_data));
                accepted++;
            end
            stalled_prev = out_valid && !out_ready;
            held = out_data;
        end else begin
            exp_q.delete();
            last_mask_fire = 0;
            prev_issue = 0;
            stalled_prev = 0;
            run_mode = 0;
        end
        @(posedge ck);
        #1;
    endtask

    task automatic load_mask(input logic [63:0] m);
        int unsigned budget = 0;
        run_mode = 0;
        mask_valid = 1;
        mask_data = m;
        last_mask_fire = 0;
        while (!last_mask_fire && budget < 64) begin
            cycle();
            budget++;
        end
        chk("mask_accept_bound", last_mask_fire, 1);
        mask_valid = 0;
        loading = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("load_pushnl", nlu_pushnl, 1);
            chk("load_dinp", nlu_dinp, {16'h0, m[48-16*k +: 16]});
            chk("load_in_ready", in_ready, 0);
            chk("load_busy", busy, 1);
            cycle();
        end
        loading = 0;
        run_mode = 1;
    endtask

    task automatic wait_empty();
        int unsigned budget = 0;
        out_ready = 1;
        in_valid = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 100) begin
            cycle();
            budget++;
        end
        chk("drain_bound", exp_q.size(), 0);
        chk("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent, base, base_d;
        int unsigned budget;
        logic [63:0] m2;

        rst = 1; mask_valid = 0; mask_data = '0; in_valid = 0; in_data = '0; out_ready = 0;
        repeat (3) cycle();

        // Reset values, with requests offered while rst is held
        mask_valid = 1; mask_data = PRESENT_ANF; in_valid = 1; in_data = 32'h1;
        #1;
        chk("rst_mask_ready", mask_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pushnl", nlu_pushnl, 0);
        chk("rst_dinp", nlu_dinp, 0);
        chk("const_mac", nlu_mac, 1);
        chk("const_zero", {nlu_mode, nlu_modenl, nlu_pushl, nlu_acc, nlu_sel, nlu_sro}, 0);
        cycle();
        rst = 0; mask_valid = 0; in_valid = 0;

        // Data offered without a mask is never taken
        in_valid = 1; in_data = $urandom;
        repeat (4) begin
            #1;
            chk("nomask_in_ready", in_ready, 0);
            chk("nomask_mask_ready", mask_ready, 1);
            chk("nomask_busy", busy, 1);
            cycle();
        end
        chk("nomask_accepted", accepted, 0);
        in_valid = 0;

        load_mask(PRESENT_ANF);

        // Known vectors, back-to-back, and first-result latency
        out_ready = 0; base = accepted;
        in_valid = 1; in_data = 32'h01234567;
        cycle();
        in_data = 32'h89ABCDEF;
        cycle();
        in_valid = 0;
        chk("vec_b2b", accepted, base + 2);
        for (int k = 2; k <= TLAT + 1; k++) begin
            #1;
            chk("vec_early_valid", out_valid, 0);
            cycle();
        end
        #1;
        chk("vec_latency", out_valid, 1);
        chk("vec_first", out_data, 32'hC56B90AD);
        out_ready = 1;
        cycle();
        #1;
        chk("vec_second_valid", out_valid, 1);
        chk("vec_second", out_data, 32'h3EF84712);
        wait_empty();

        // Consumer stalled: only DEPTH words accepted, then all 10 delivered in order
        out_ready = 0; sent = 0; base_d = delivered;
        in_valid = 1; in_data = $urandom;
        for (int n = 0; n < 16; n++) begin
            cycle();
            if (prev_issue) begin sent++; in_data = $urandom; end
        end
        chk("stall_accepted", sent, TDEPTH);
        #1;
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1; budget = 0;
        while ((sent < 10 || exp_q.size() != 0) && budget < 300) begin
            in_valid = (sent < 10);
            cycle();
            if (prev_issue) begin sent++; in_data = $urandom; end
            budget++;
        end
        in_valid = 0;
        chk("stall_total", sent, 10);
        chk("stall_delivered", delivered - base_d, 10);

        // Mask request with words in flight: drain first, no data accepted until load ends
        wait_empty();
        base = accepted; in_valid = 1;
        for (int n = 0; n < 3; n++) begin
            in_data = $urandom;
            cycle();
        end
        chk("drain_issued", accepted, base + 3);
        base = accepted;
        m2 = {$urandom, $urandom};
        mask_valid = 1; mask_data = m2; in_data = $urandom;
        #1;
        chk("drain_mask_ready", mask_ready, 0);
        chk("drain_busy", busy, 1);
        load_mask(m2);
        in_valid = 0;
        chk("drain_no_data", accepted, base);
        wait_empty();

        // Reset during the second LOAD cycle
        run_mode = 0; mask_valid = 1; mask_data = PRESENT_ANF; last_mask_fire = 0; budget = 0;
        while (!last_mask_fire && budget < 64) begin
            cycle();
            budget++;
        end
        chk("rl_mask_accept", last_mask_fire, 1);
        mask_valid = 0; loading = 1;
        #1;
        chk("rl_load0", nlu_pushnl, 1);
        cycle();
        rst = 1;
        cycle();
        rst = 0; loading = 0;
        #1;
        chk("rl_pushnl", nlu_pushnl, 0);
        chk("rl_dinp", nlu_dinp, 0);
        chk("rl_in_ready", in_ready, 0);
        chk("rl_mask_ready", mask_ready, 1);
        chk("rl_busy", busy, 1);
        base = accepted; in_valid = 1; in_data = $urandom;
        repeat (3) cycle();
        in_valid = 0;
        chk("rl_no_data", accepted, base);
        load_mask(PRESENT_ANF);

        // Reset with words in flight discards their results
        out_ready = 0; in_valid = 1;
        for (int n = 0; n < 2; n++) begin
            in_data = $urandom;
            cycle();
        end
        in_valid = 0; rst = 1;
        cycle();
        rst = 0;
        for (int n = 0; n < 6; n++) begin
            #1;
            chk("rr_discard", out_valid, 0);
            cycle();
        end
        chk("rr_nomask", mask_ready, 1);
        load_mask(PRESENT_ANF);

        // Random traffic with mask reloads in between
        for (int b = 0; b < 3; b++) begin
            for (int n = 0; n < 150; n++) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 5);
                in_data   = $urandom;
                cycle();
            end
            in_valid = 0;
            m2 = {$urandom, $urandom};
            load_mask(m2);
        end
        wait_empty();
        #1;
        chk("end_busy", busy, 0);
        chk("end_in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
